// File: rtl/alarm_ring_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ring_sequencer_if
//  Description : Signal bundle between the alarm controls / annunciator and
//                the ring sequencer. The "master" side drives the user and
//                timebase inputs; the "slave" side is the sequencer.
//  Signals     : enable, alarmMatch, pulse1min, snoozeBtn, stopBtn  (to seq)
//                buzzer, ringing, snoozing, snoozeLeft[5:0],
//                snoozeUsed[2:0]                                     (from seq)
//  Revision    : 1.0  initial release
// ============================================================================
interface alarm_ring_sequencer_if;
    logic       enable;
    logic       alarmMatch;
    logic       pulse1min;
    logic       snoozeBtn;
    logic       stopBtn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [5:0] snoozeLeft;
    logic [2:0] snoozeUsed;

    modport master (
        output enable, alarmMatch, pulse1min, snoozeBtn, stopBtn,
        input  buzzer, ringing, snoozing, snoozeLeft, snoozeUsed
    );

    modport slave (
        input  enable, alarmMatch, pulse1min, snoozeBtn, stopBtn,
        output buzzer, ringing, snoozing, snoozeLeft, snoozeUsed
    );
endinterface
`default_nettype wire

// File: rtl/alarm_ring_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ring_sequencer
//  Description : Turns the clock==alarm match level into a ringing sequence:
//                a beep-gated buzzer tone with snooze, stop, a snooze limit
//                and an unattended-ring timeout counted in clock minutes.
//  Ports       : clk5MHz  - 5 MHz system clock
//                reset    - asynchronous, active-high
//                io_bus   - alarm_ring_sequencer_if.slave
//                  in : enable, alarmMatch, pulse1min, snoozeBtn, stopBtn
//                  out: buzzer, ringing, snoozing, snoozeLeft, snoozeUsed
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_ring_sequencer #(
    parameter int TONE_DIV         = 1250,
    parameter int BEEP_DIV         = 1250000,
    parameter int SNOOZE_MIN       = 5,
    parameter int MAX_SNOOZE       = 3,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  wire logic              clk5MHz,
    input  wire logic              reset,
    alarm_ring_sequencer_if.slave  io_bus
);

    localparam int c_TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int c_BEEP_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

    localparam logic [c_TONE_W-1:0] c_TONE_LAST  = c_TONE_W'(TONE_DIV - 1);
    localparam logic [c_BEEP_W-1:0] c_BEEP_LAST  = c_BEEP_W'(BEEP_DIV - 1);
    localparam logic [5:0]          c_SNOOZE_MIN = 6'(SNOOZE_MIN);
    localparam logic [5:0]          c_RING_LAST  = 6'(RING_TIMEOUT_MIN - 1);
    localparam logic [2:0]          c_MAX_SNOOZE = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    // Edge-detect history; reset high so a level already present at reset
    // release is not mistaken for a fresh press or match.
    logic r_match_q, r_snooze_q, r_stop_q;
    logic w_match_rise, w_snooze_rise, w_stop_rise;

    logic [5:0]          r_snooze_left, w_snooze_left_nxt;
    logic [2:0]          r_snooze_used, w_snooze_used_nxt;
    logic [5:0]          r_ring_min,    w_ring_min_nxt;
    logic                w_restart;

    logic [c_TONE_W-1:0] r_tone_cnt, w_tone_cnt_nxt;
    logic                r_tone_sq,  w_tone_sq_nxt;
    logic [c_BEEP_W-1:0] r_beep_cnt, w_beep_cnt_nxt;
    logic                r_beep_on,  w_beep_on_nxt;
    logic                r_buzzer,   w_buzzer_nxt;

    assign w_match_rise  = io_bus.alarmMatch & ~r_match_q;
    assign w_snooze_rise = io_bus.snoozeBtn  & ~r_snooze_q;
    assign w_stop_rise   = io_bus.stopBtn    & ~r_stop_q;

    // ------------------------------------------------------------------
    // Next-state logic. Priority: enable low > stop > snooze > minute.
    // w_restart marks every entry into RINGING so the tone/beep phase
    // and the ring-minute count start fresh.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_snooze_left_nxt = r_snooze_left;
        w_snooze_used_nxt = r_snooze_used;
        w_ring_min_nxt    = r_ring_min;
        w_restart         = 1'b0;

        if (!io_bus.enable) begin
            w_state_nxt       = S_IDLE;
            w_snooze_left_nxt = '0;
            w_snooze_used_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_match_rise) begin
                        w_state_nxt = S_RINGING;
                        w_restart   = 1'b1;
                    end
                end
                S_RINGING: begin
                    if (w_stop_rise) begin
                        w_state_nxt = S_DONE;
                    end else if (w_snooze_rise) begin
                        // Once the snooze allowance is spent, snooze acts as stop.
                        if (r_snooze_used < c_MAX_SNOOZE) begin
                            w_state_nxt       = S_SNOOZE;
                            w_snooze_left_nxt = c_SNOOZE_MIN;
                            w_snooze_used_nxt = r_snooze_used + 3'd1;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else if (io_bus.pulse1min) begin
                        if (r_ring_min >= c_RING_LAST) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_ring_min_nxt = r_ring_min + 6'd1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (w_stop_rise) begin
                        w_state_nxt = S_DONE;
                    end else if (io_bus.pulse1min) begin
                        if (r_snooze_left <= 6'd1) begin
                            w_state_nxt       = S_RINGING;
                            w_snooze_left_nxt = '0;
                            w_restart         = 1'b1;
                        end else begin
                            w_snooze_left_nxt = r_snooze_left - 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    // Wait for the match window to close so the same minute
                    // cannot re-trigger.
                    if (!io_bus.alarmMatch) begin
                        w_state_nxt       = S_IDLE;
                        w_snooze_left_nxt = '0;
                        w_snooze_used_nxt = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (w_restart) begin
            w_ring_min_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Tone and beep dividers. The tone square starts low and the beep
    // cadence starts in its ON phase on every entry into RINGING.
    // ------------------------------------------------------------------
    always_comb begin
        w_tone_cnt_nxt = r_tone_cnt;
        w_tone_sq_nxt  = r_tone_sq;
        w_beep_cnt_nxt = r_beep_cnt;
        w_beep_on_nxt  = r_beep_on;

        if (w_restart) begin
            w_tone_cnt_nxt = '0;
            w_tone_sq_nxt  = 1'b0;
            w_beep_cnt_nxt = '0;
            w_beep_on_nxt  = 1'b1;
        end else if (r_state == S_RINGING) begin
            if (r_tone_cnt == c_TONE_LAST) begin
                w_tone_cnt_nxt = '0;
                w_tone_sq_nxt  = ~r_tone_sq;
            end else begin
                w_tone_cnt_nxt = r_tone_cnt + 1'b1;
            end
            if (r_beep_cnt == c_BEEP_LAST) begin
                w_beep_cnt_nxt = '0;
                w_beep_on_nxt  = ~r_beep_on;
            end else begin
                w_beep_cnt_nxt = r_beep_cnt + 1'b1;
            end
        end
    end

    // Buzzer is built from next-cycle values so it lines up with the
    // ringing flag and is silent in the very cycle RINGING is left.
    assign w_buzzer_nxt = (w_state_nxt == S_RINGING) & w_tone_sq_nxt & w_beep_on_nxt;

    always_ff @(posedge clk5MHz or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_match_q     <= 1'b1;
            r_snooze_q    <= 1'b1;
            r_stop_q      <= 1'b1;
            r_snooze_left <= '0;
            r_snooze_used <= '0;
            r_ring_min    <= '0;
            r_tone_cnt    <= '0;
            r_tone_sq     <= 1'b0;
            r_beep_cnt    <= '0;
            r_beep_on     <= 1'b0;
            r_buzzer      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_match_q     <= io_bus.alarmMatch;
            r_snooze_q    <= io_bus.snoozeBtn;
            r_stop_q      <= io_bus.stopBtn;
            r_snooze_left <= w_snooze_left_nxt;
            r_snooze_used <= w_snooze_used_nxt;
            r_ring_min    <= w_ring_min_nxt;
            r_tone_cnt    <= w_tone_cnt_nxt;
            r_tone_sq     <= w_tone_sq_nxt;
            r_beep_cnt    <= w_beep_cnt_nxt;
            r_beep_on     <= w_beep_on_nxt;
            r_buzzer      <= w_buzzer_nxt;
        end
    end

    assign io_bus.buzzer     = r_buzzer;
    assign io_bus.ringing    = (r_state == S_RINGING);
    assign io_bus.snoozing   = (r_state == S_SNOOZE);
    assign io_bus.snoozeLeft = r_snooze_left;
    assign io_bus.snoozeUsed = r_snooze_used;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_ring_sequencer
//  Description : Self-checking bench for alarm_ring_sequencer with small
//                divider/minute parameters. A mode-level reference model
//                (ring cycle index, minute and snooze tallies) predicts the
//                outputs each cycle; literal expectations pin key points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_ring_sequencer;

    localparam int TONE_DIV         = 2;
    localparam int BEEP_DIV         = 8;
    localparam int SNOOZE_MIN       = 2;
    localparam int MAX_SNOOZE       = 2;
    localparam int RING_TIMEOUT_MIN = 3;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;
    localparam int M_DONE = 3;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    alarm_ring_sequencer_if bus();

    alarm_ring_sequencer #(
        .TONE_DIV         (TONE_DIV),
        .BEEP_DIV         (BEEP_DIV),
        .SNOOZE_MIN       (SNOOZE_MIN),
        .MAX_SNOOZE       (MAX_SNOOZE),
        .RING_TIMEOUT_MIN (RING_TIMEOUT_MIN)
    ) dut (
        .clk5MHz (clk),
        .reset   (rst),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   m_state, m_k, m_min, m_left, m_used;
    logic p_match, p_snz, p_stop;

    always @(posedge clk or posedge rst) begin : p_model
        logic mr, sr, tr;
        if (rst) begin
            m_state <= M_IDLE;
            m_k     <= 0;
            m_min   <= 0;
            m_left  <= 0;
            m_used  <= 0;
            p_match <= 1'b1;
            p_snz   <= 1'b1;
            p_stop  <= 1'b1;
        end else begin
            mr = bus.alarmMatch & ~p_match;
            sr = bus.snoozeBtn  & ~p_snz;
            tr = bus.stopBtn    & ~p_stop;
            p_match <= bus.alarmMatch;
            p_snz   <= bus.snoozeBtn;
            p_stop  <= bus.stopBtn;
            m_k     <= m_k + 1;
            if (!bus.enable) begin
                m_state <= M_IDLE;
                m_left  <= 0;
                m_used  <= 0;
            end else begin
                case (m_state)
                    M_IDLE: if (mr) begin
                        m_state <= M_RING; m_k <= 0; m_min <= 0;
                    end
                    M_RING: begin
                        if (tr) m_state <= M_DONE;
                        else if (sr) begin
                            if (m_used < MAX_SNOOZE) begin
                                m_state <= M_SNZ;
                                m_left  <= SNOOZE_MIN;
                                m_used  <= m_used + 1;
                            end else m_state <= M_DONE;
                        end else if (bus.pulse1min) begin
                            m_min <= m_min + 1;
                            if (m_min + 1 >= RING_TIMEOUT_MIN) m_state <= M_DONE;
                        end
                    end
                    M_SNZ: begin
                        if (tr) m_state <= M_DONE;
                        else if (bus.pulse1min) begin
                            m_left <= m_left - 1;
                            if (m_left == 1) begin
                                m_state <= M_RING; m_k <= 0; m_min <= 0;
                            end
                        end
                    end
                    default: if (!bus.alarmMatch) begin
                        m_state <= M_IDLE; m_left <= 0; m_used <= 0;
                    end
                endcase
            end
        end
    end

    // Buzzer from the ring-cycle index: tone high in odd TONE_DIV slots,
    // beep ON in even BEEP_DIV slots.
    function automatic logic exp_buzz(input int st, input int k);
        return (st == M_RING) && (((k / TONE_DIV) % 2) == 1) && (((k / BEEP_DIV) % 2) == 0);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            logic eb, er, es;
            eb = exp_buzz(m_state, m_k);
            er = (m_state == M_RING);
            es = (m_state == M_SNZ);
            n_tests++;
            if (bus.buzzer !== eb || bus.ringing !== er || bus.snoozing !== es ||
                bus.snoozeLeft !== 6'(m_left) || bus.snoozeUsed !== 3'(m_used)) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: buz/ring/snz/left/used got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                         $time, bus.buzzer, bus.ringing, bus.snoozing, bus.snoozeLeft, bus.snoozeUsed,
                         eb, er, es, m_left, m_used);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic minute();
        bus.pulse1min = 1'b1;
        @(negedge clk);
        bus.pulse1min = 1'b0;
    endtask

    task automatic press(input logic snz, input logic stp, input logic pls);
        bus.snoozeBtn = snz;
        bus.stopBtn   = stp;
        bus.pulse1min = pls;
        @(negedge clk);
        bus.snoozeBtn = 1'b0;
        bus.stopBtn   = 1'b0;
        bus.pulse1min = 1'b0;
    endtask

    task automatic start_ring();
        bus.alarmMatch = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_match();
        bus.alarmMatch = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] pat;

    initial begin
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.alarmMatch = 1'b0;
        bus.pulse1min  = 1'b0;
        bus.snoozeBtn  = 1'b0;
        bus.stopBtn    = 1'b0;
        step(3);
        check("reset_buzzer",  {7'd0, bus.buzzer},  8'd0);
        check("reset_ringing", {7'd0, bus.ringing}, 8'd0);
        check("reset_left",    {2'd0, bus.snoozeLeft}, 8'd0);
        rst        = 1'b0;
        bus.enable = 1'b1;
        step(2);

        // Ring and beep cadence: tone period 4 cycles, beep 8 on / 8 off.
        pat = 16'b0000_0000_1100_1100;
        start_ring();
        check("t1_ringing", {7'd0, bus.ringing}, 8'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step(1);
            check($sformatf("t1_buzz_%0d", i), {7'd0, bus.buzzer}, {7'd0, pat[i]});
        end
        press(1'b0, 1'b1, 1'b0);
        check("t1_stop_ring", {7'd0, bus.ringing}, 8'd0);
        end_match();
        step(1);

        // Snooze, expiry back to ringing.
        start_ring();
        step(3);
        press(1'b1, 1'b0, 1'b0);
        check("t2_snoozing", {7'd0, bus.snoozing}, 8'd1);
        check("t2_left",     {2'd0, bus.snoozeLeft}, 8'd2);
        check("t2_used",     {5'd0, bus.snoozeUsed}, 8'd1);
        step(2);
        minute();
        check("t2_left_dec", {2'd0, bus.snoozeLeft}, 8'd1);
        step(1);
        minute();
        check("t2_reringing", {7'd0, bus.ringing}, 8'd1);
        check("t2_left_zero", {2'd0, bus.snoozeLeft}, 8'd0);

        // Second snooze, then third press exhausts allowance and stops.
        step(2);
        press(1'b1, 1'b0, 1'b0);
        check("t3_used2", {5'd0, bus.snoozeUsed}, 8'd2);
        step(1); minute(); step(1); minute();
        check("t3_reringing", {7'd0, bus.ringing}, 8'd1);
        step(2);
        press(1'b1, 1'b0, 1'b0);
        check("t3_done_ring", {7'd0, bus.ringing},  8'd0);
        check("t3_done_snz",  {7'd0, bus.snoozing}, 8'd0);
        check("t3_done_buz",  {7'd0, bus.buzzer},   8'd0);
        step(2);
        end_match();
        check("t3_idle_used", {5'd0, bus.snoozeUsed}, 8'd0);

        // Unattended timeout after three minutes.
        start_ring();
        step(1); minute(); step(1); minute();
        check("t4_still_ring", {7'd0, bus.ringing}, 8'd1);
        step(1); minute();
        check("t4_timeout", {7'd0, bus.ringing}, 8'd0);
        end_match(); step(1);

        // Snooze on the timeout minute snoozes; stop on snooze expiry stops.
        start_ring();
        minute(); step(1); minute(); step(1);
        press(1'b1, 1'b0, 1'b1);
        check("t4_snz_on_timeout", {7'd0, bus.snoozing}, 8'd1);
        step(1); minute(); step(1);
        press(1'b0, 1'b1, 1'b1);
        check("t4_stop_on_expiry_ring", {7'd0, bus.ringing},  8'd0);
        check("t4_stop_on_expiry_snz",  {7'd0, bus.snoozing}, 8'd0);
        end_match(); step(1);

        // Stop and snooze together: stop wins, snooze count untouched.
        start_ring();
        step(1);
        press(1'b1, 1'b0, 1'b0);
        step(1); minute(); step(1); minute();
        step(1);
        press(1'b1, 1'b1, 1'b0);
        check("t4_both_ring", {7'd0, bus.ringing},  8'd0);
        check("t4_both_snz",  {7'd0, bus.snoozing}, 8'd0);
        check("t4_both_used", {5'd0, bus.snoozeUsed}, 8'd1);
        end_match(); step(1);

        // Enable dropped mid-ring.
        start_ring();
        step(2);
        check("t5_buz_on", {7'd0, bus.buzzer}, 8'd1);
        bus.enable = 1'b0;
        @(negedge clk);
        check("t5_en_ring", {7'd0, bus.ringing}, 8'd0);
        check("t5_en_buz",  {7'd0, bus.buzzer},  8'd0);
        bus.enable = 1'b1;
        step(2);
        check("t5_no_rering", {7'd0, bus.ringing}, 8'd0);
        end_match(); step(1);

        // Asynchronous reset mid-ring, released with match and snooze high.
        start_ring();
        step(2);
        #2 rst = 1'b1;
        #1;
        check("t5_async_buz",  {7'd0, bus.buzzer},  8'd0);
        check("t5_async_ring", {7'd0, bus.ringing}, 8'd0);
        bus.snoozeBtn = 1'b1;
        step(2);
        rst = 1'b0;
        step(4);
        check("t5_rel_ring", {7'd0, bus.ringing},  8'd0);
        check("t5_rel_snz",  {7'd0, bus.snoozing}, 8'd0);
        bus.snoozeBtn = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
